// File: rtl/sram_burst_ctr_if.sv
// Host-side request/response bundle for sram_burst_ctr.
// The master (pipeline) raises mem_r_en/mem_w_en and holds them while
// sram_not_ready is high; read_data is valid when sram_not_ready drops.
interface sram_burst_ctr_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) ();
  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              sram_not_ready;

  modport master (
    output mem_r_en, mem_w_en, address, write_data,
    input  read_data, sram_not_ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, address, write_data,
    output read_data, sram_not_ready
  );
endinterface

// File: rtl/sram_burst_ctr.sv
// Burst controller between a host word port and a narrow asynchronous SRAM.
// One host word is moved as DATA_W/SRAM_DW beats, least significant slice
// first, followed by WAIT_CYC recovery cycles and a one-cycle DONE.
// Optional build macro SRAM_CTR_RDBUF_EN adds a one-entry read buffer that
// answers a repeated read of the last-read address without touching the SRAM.
module sram_burst_ctr #(
  parameter int DATA_W   = 32,
  parameter int SRAM_DW  = 16,
  parameter int ADDR_W   = 16,
  parameter int SRAM_AW  = 18,
  parameter int WAIT_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_burst_ctr_if.slave    host,
  output logic [SRAM_AW-1:0] sram_address,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  inout  wire  [SRAM_DW-1:0] sram_data
);

  localparam int N    = DATA_W / SRAM_DW;
  localparam int LOGN = (N > 1) ? $clog2(N) : 0;
  localparam int BW   = (N > 1) ? LOGN : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic              op_rd_q;
  logic [BW-1:0]     beat_q;
  logic [3:0]        wait_q;
  logic [DATA_W-1:0] read_data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req;
  logic              accept;
  logic              start;
  logic              buf_hit;
  logic              last_beat;
  logic              bus_drive;

  // SRAM address of beat k: host word address with the beat index appended.
  function automatic logic [SRAM_AW-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [BW-1:0]     k);
    logic [SRAM_AW-1:0] r;
    r = SRAM_AW'(a) << LOGN;
    r = r | SRAM_AW'(k);
    return r;
  endfunction

  assign req       = host.mem_r_en | host.mem_w_en;
  assign last_beat = (beat_q == BW'(N - 1));
  assign start     = accept && !buf_hit;

`ifdef SRAM_CTR_RDBUF_EN
  logic [ADDR_W-1:0] buf_tag_q;
  logic              buf_vld_q;

  assign buf_hit = host.mem_r_en && buf_vld_q && (host.address == buf_tag_q);

  // Buffer valid: set when a read burst completes, dropped by any accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld_q <= 1'b0;
    end else if (state_q == ACCESS && op_rd_q && last_beat) begin
      buf_vld_q <= 1'b1;
    end else if (accept && !host.mem_r_en) begin
      buf_vld_q <= 1'b0;
    end
  end

  // Buffer tag: address of the most recently completed read.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && op_rd_q && last_beat) begin
      buf_tag_q <= addr_q;
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  // State register; reset forces IDLE so the strobes release at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and SRAM strobes; strobes are pure decodes of the state.
  always_comb begin
    state_d   = state_q;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    bus_drive = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = buf_hit ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (op_rd_q) begin
          sram_oe_n = 1'b0;
        end else begin
          sram_we_n = 1'b0;
          bus_drive = 1'b1;
        end
        if (last_beat) state_d = (WAIT_CYC == 0) ? DONE : WAIT;
      end
      WAIT: begin
        if (wait_q <= 4'd1) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat/recovery counters, SRAM address register and read word assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_rd_q      <= 1'b0;
      beat_q       <= '0;
      wait_q       <= '0;
      read_data_q  <= '0;
      sram_address <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) op_rd_q <= host.mem_r_en;
          if (start) begin
            beat_q       <= '0;
            sram_address <= beat_addr(host.address, '0);
          end
        end
        ACCESS: begin
          if (op_rd_q) read_data_q[beat_q*SRAM_DW +: SRAM_DW] <= sram_data;
          if (last_beat) begin
            wait_q <= 4'(WAIT_CYC);
          end else begin
            beat_q       <= beat_q + 1'b1;
            sram_address <= beat_addr(addr_q, beat_q + 1'b1);
          end
        end
        WAIT: wait_q <= wait_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Request operands captured once at acceptance; held for the whole burst.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= host.address;
      wdata_q <= host.write_data;
    end
  end

  assign sram_data           = bus_drive ? wdata_q[beat_q*SRAM_DW +: SRAM_DW] : 'z;
  assign host.read_data      = read_data_q;
  assign host.sram_not_ready = req && (state_q != DONE);

endmodule

// File: doc/sram_burst_ctr.md
SRAM_BURST_CTR -- requirements
Module: sram_burst_ctr

Interface
REQ-001 SHALL have parameter DATA_W, default 32: host word width; SHALL be a multiple of SRAM_DW, with DATA_W/SRAM_DW a power of two, at least 1.
REQ-002 SHALL have parameter SRAM_DW, default 16: SRAM data bus width.
REQ-003 SHALL have parameter ADDR_W, default 16: host word-address width.
REQ-004 SHALL have parameter SRAM_AW, default 18: SRAM address width; SHALL satisfy ADDR_W+log2(DATA_W/SRAM_DW) <= SRAM_AW.
REQ-005 SHALL have parameter WAIT_CYC, default 4: post-access recovery cycles, range 0..15.
REQ-006 SHALL provide one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock; all state changes on the rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 mem_r_en  in  1  read request, held until sram_not_ready is low.
REQ-010 mem_w_en  in  1  write request, held until sram_not_ready is low.
REQ-011 address  in  ADDR_W  host word address.
REQ-012 write_data  in  DATA_W  write word.
REQ-013 read_data  out  DATA_W  registered read word.
REQ-014 sram_not_ready  out  1  pipeline stall.
REQ-015 sram_address  out  SRAM_AW  SRAM address.
REQ-016 sram_we_n  out  1  SRAM write enable, active-low.
REQ-017 sram_oe_n  out  1  SRAM output enable, active-low.
REQ-018 sram_data  inout  SRAM_DW  SRAM data bus.

Function
REQ-019 N = DATA_W/SRAM_DW beats; beat k SHALL use sram_address = zero-extended {addr_q, k[log2(N)-1:0]}, with slice k = bits [k*SRAM_DW +: SRAM_DW].
REQ-020 States SHALL be IDLE, ACCESS, WAIT and DONE.
REQ-021 IDLE, request present: SHALL latch address, write_data and op (read wins if both enables are high), clear beat counter, go to ACCESS.
REQ-022 ACCESS beat k, read: sram_oe_n=0, sram_we_n=1; slice k of read_data SHALL capture sram_data at the end of the cycle.
REQ-023 ACCESS beat k, write: sram_we_n=0, sram_oe_n=1; sram_data SHALL be driven with latched slice k; bus is high-Z in every other state/op.
REQ-024 After beat N-1: go to WAIT with counter loaded to WAIT_CYC, or go directly to DONE if WAIT_CYC=0; WAIT SHALL decrement the counter and move to DONE on 1.
REQ-025 DONE SHALL last one cycle, then go to IDLE.
REQ-026 sram_not_ready SHALL be (mem_r_en|mem_w_en) && state!=DONE, which gives N+WAIT_CYC+1 stall cycles per access.
REQ-027 Outside ACCESS: sram_we_n=1, sram_oe_n=1, sram_address holds the last value.
REQ-028 A request deasserted mid-operation SHALL NOT abort it; the sequence SHALL complete through DONE.
REQ-029 read_data SHALL change only in ACCESS of a read.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE, counters=0, read_data=0, sram_address=0, sram_we_n=1, sram_oe_n=1, sram_data high-Z.
REQ-031 Reset asserted mid-write SHALL deassert sram_we_n immediately; the partial write is not retried.

Configuration
REQ-032 Macro SRAM_CTR_RDBUF_EN SHALL compile in a one-entry read buffer: a tag register plus a valid bit.
REQ-033 With SRAM_CTR_RDBUF_EN defined:
- Completion of a read SHALL set tag=address and valid=1.
- A read in IDLE whose address equals the tag while valid=1 SHALL go straight to DONE, with 1 stall cycle and no SRAM strobe; read_data is unchanged.
- Any accepted write SHALL clear valid.
- Reset SHALL clear valid.
REQ-034 Without SRAM_CTR_RDBUF_EN: every read SHALL access SRAM; no buffer logic.

Verification
REQ-035 Defaults, write addr 0x0010 data 0xDEADBEEF: beats at 0x00020 (0xBEEF) and 0x00021 (0xDEAD), we_n low 2 cycles, not_ready high 7 cycles.
REQ-036 Read 0x0010 after REQ-035: oe_n low 2 cycles, read_data=0xDEADBEEF on the cycle not_ready drops.
REQ-037 DATA_W=64, WAIT_CYC=0: read addr 0x0003 -> SRAM addresses 0x0C..0x0F, not_ready high 5 cycles.
REQ-038 mem_r_en and mem_w_en both high -> read performed, sram_we_n never low.
REQ-039 rst_n pulsed low during write beat 1 -> we_n=1 and bus high-Z within the same cycle, state IDLE, read_data=0.
REQ-040 SRAM_CTR_RDBUF_EN defined:
- Repeat read 0x0010 -> 1 stall cycle, no oe_n strobe.
- Write 0x0010 then read 0x0010 -> full SRAM read.
